// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial signed adder/subtractor.
// One 4-bit carry-lookahead slice is reused across NIBBLES cycles, LSB nibble
// first, with the inter-nibble carry held in a register.
//
// Handshake: start is a request that is accepted on a rising edge only while
// busy==0 (state IDLE or DONE); a, b and sub are sampled on that same edge.
// busy is high for exactly NIBBLES cycles, then done pulses for one cycle with
// result/ovfl/cout/zero valid. Those outputs stay unchanged until the next
// accepted start begins overwriting them.

// 4-bit carry-lookahead slice: SUM, carry out and signed overflow.
module nibble_serial_add_ctrl_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       ovfl
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Generate/propagate terms and flattened lookahead carries.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
    // Signed overflow: carry into the sign bit differs from carry out of it.
    ovfl = c[3] ^ c[4];
  end

endmodule

// Sequencer around the shared slice.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4,
  parameter bit SAT_EN  = 1'b1,
  localparam int W      = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         ovfl,
  output logic         cout,
  output logic         zero
);

  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          carry, carry_n;
  logic [W-1:0]  opa, opa_n;
  logic [W-1:0]  opb, opb_n;
  logic [W-1:0]  result_q, result_n;
  logic          ovfl_q, ovfl_n;
  logic          cout_q, cout_n;
  logic          zero_q, zero_n;

  logic [3:0]    sl_a, sl_b, sl_sum;
  logic          sl_cout, sl_ovfl;
  logic [W-1:0]  run_res;
  logic [W-1:0]  sat_val;

  // Select the operand nibbles addressed by the counter.
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt == CW'(i)) begin
        sl_a = opa[4*i +: 4];
        sl_b = opb[4*i +: 4];
      end
    end
  end

  nibble_serial_add_ctrl_cla4 u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .sum  (sl_sum),
    .cout (sl_cout),
    .ovfl (sl_ovfl)
  );

  // Result with the current slice sum merged into its nibble; saturation
  // value chosen by the sign of A (overflow implies A and B' share a sign).
  always_comb begin
    run_res = result_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt == CW'(i)) begin
        run_res[4*i +: 4] = sl_sum;
      end
    end
    sat_val = opa[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    carry_n  = carry;
    opa_n    = opa;
    opb_n    = opb;
    result_n = result_q;
    ovfl_n   = ovfl_q;
    cout_n   = cout_q;
    zero_n   = zero_q;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction as A + ~B + 1: the +1 rides in on the first carry.
          opa_n   = a;
          opb_n   = sub ? ~b : b;
          carry_n = sub;
          cnt_n   = '0;
          state_n = RUN;
        end else if (state == DONE) begin
          state_n = IDLE;
        end
      end
      RUN: begin
        result_n = run_res;
        carry_n  = sl_cout;
        if (cnt == LAST) begin
          cout_n = sl_cout;
          ovfl_n = sl_ovfl;
          if (SAT_EN && sl_ovfl) begin
            result_n = sat_val;
          end
          zero_n  = (result_n == '0);
          state_n = DONE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Datapath registers: counter, carry, operands, result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      carry    <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      result_q <= '0;
      ovfl_q   <= 1'b0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      carry    <= carry_n;
      opa      <= opa_n;
      opb      <= opb_n;
      result_q <= result_n;
      ovfl_q   <= ovfl_n;
      cout_q   <= cout_n;
      zero_q   <= zero_n;
    end
  end

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign result = result_q;
  assign ovfl   = ovfl_q;
  assign cout   = cout_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: a saturating and a wrapping 16-bit
// instance share stimulus; a 1-nibble instance has its own inputs.
// Expected responses are queued at issue time and popped by the monitor.
module tb_nibble_serial_add_ctrl;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        sub   = 1'b0;
  logic [15:0] a     = '0;
  logic [15:0] b     = '0;
  logic        busy, done, ovfl, cout, zero;
  logic [15:0] result;
  logic        busy_w, done_w, ovfl_w, cout_w, zero_w;
  logic [15:0] result_w;

  logic        start1 = 1'b0;
  logic        sub1   = 1'b0;
  logic [3:0]  a1     = '0;
  logic [3:0]  b1     = '0;
  logic        busy1, done1, ovfl1, cout1, zero1;
  logic [3:0]  result1;

  nibble_serial_add_ctrl #(.NIBBLES(4), .SAT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .ovfl(ovfl), .cout(cout), .zero(zero)
  );

  nibble_serial_add_ctrl #(.NIBBLES(4), .SAT_EN(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy_w), .done(done_w), .result(result_w), .ovfl(ovfl_w), .cout(cout_w), .zero(zero_w)
  );

  nibble_serial_add_ctrl #(.NIBBLES(1), .SAT_EN(1'b1)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .result(result1), .ovfl(ovfl1), .cout(cout1), .zero(zero1)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [18:0] exp_q[$];    // {result, ovfl, cout, zero} for dut
  logic [18:0] exp_w_q[$];  // same for dut_wrap
  logic [6:0]  exp_1_q[$];  // same for dut_n1
  logic [18:0] mon_e;
  logic [18:0] mon_ew;
  logic [6:0]  mon_e1;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: compare every done pulse against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (exp_q.size() == 0) chk("sat_unexpected_done", 16'(1), 16'(0));
        else begin
          mon_e = exp_q.pop_front();
          chk("sat_result", result, mon_e[18:3]);
          chk("sat_ovfl", 16'(ovfl), 16'(mon_e[2]));
          chk("sat_cout", 16'(cout), 16'(mon_e[1]));
          chk("sat_zero", 16'(zero), 16'(mon_e[0]));
        end
      end
      if (done_w) begin
        if (exp_w_q.size() == 0) chk("wrap_unexpected_done", 16'(1), 16'(0));
        else begin
          mon_ew = exp_w_q.pop_front();
          chk("wrap_result", result_w, mon_ew[18:3]);
          chk("wrap_ovfl", 16'(ovfl_w), 16'(mon_ew[2]));
          chk("wrap_cout", 16'(cout_w), 16'(mon_ew[1]));
          chk("wrap_zero", 16'(zero_w), 16'(mon_ew[0]));
        end
      end
      if (done1) begin
        if (exp_1_q.size() == 0) chk("n1_unexpected_done", 16'(1), 16'(0));
        else begin
          mon_e1 = exp_1_q.pop_front();
          chk("n1_result", 16'(result1), 16'(mon_e1[6:3]));
          chk("n1_ovfl", 16'(ovfl1), 16'(mon_e1[2]));
          chk("n1_cout", 16'(cout1), 16'(mon_e1[1]));
          chk("n1_zero", 16'(zero1), 16'(mon_e1[0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; request is accepted on the next rise.
  task automatic issue(input logic s, input logic [15:0] ta, input logic [15:0] tbv);
    sub   = s;
    a     = ta;
    b     = tbv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts falling edges before done appears; returns in the done cycle.
  task automatic wait_done(output int cyc, output int nbusy);
    bit got;
    got   = 1'b0;
    cyc   = 0;
    nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) nbusy++;
      cyc++;
    end
    if (!got) chk("done_timeout", 16'(0), 16'(1));
  endtask

  task automatic op(input logic s, input logic [15:0] ta, input logic [15:0] tbv,
                    input logic [15:0] es, input logic [15:0] ew,
                    input logic o, input logic c, input logic zs, input logic zw);
    int cyc, nb;
    exp_q.push_back({es, o, c, zs});
    exp_w_q.push_back({ew, o, c, zw});
    issue(s, ta, tbv);
    wait_done(cyc, nb);
    chk("latency", 16'(cyc), 16'(N));
  endtask

  task automatic op1(input logic s, input logic [3:0] ta, input logic [3:0] tbv,
                     input logic [3:0] e, input logic o, input logic c, input logic z);
    int cyc;
    bit got;
    exp_1_q.push_back({e, o, c, z});
    sub1   = s;
    a1     = ta;
    b1     = tbv;
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    got = 1'b0;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done1) begin
        got = 1'b1;
        break;
      end
      cyc++;
    end
    if (!got) chk("n1_done_timeout", 16'(0), 16'(1));
    chk("n1_latency", 16'(cyc), 16'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, nb, ndone;
    #1;
    chk("rst_busy", 16'(busy), 16'(0));
    chk("rst_done", 16'(done), 16'(0));
    chk("rst_result", result, 16'h0000);
    chk("rst_flags", {13'b0, ovfl, cout, zero}, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain add with busy-width check.
    exp_q.push_back({16'h2225, 1'b0, 1'b0, 1'b0});
    exp_w_q.push_back({16'h2225, 1'b0, 1'b0, 1'b0});
    issue(1'b0, 16'h1234, 16'h0FF1);
    wait_done(cyc, nb);
    chk("add_latency", 16'(cyc), 16'(4));
    chk("add_busy_cycles", 16'(nb), 16'(4));
    @(negedge clk);
    @(negedge clk);
    chk("held_result", result, 16'h2225);
    chk("idle_busy", 16'(busy), 16'(0));

    // Overflow and subtract cases (saturated vs wrapped).
    op(1'b0, 16'h7FFF, 16'h0001, 16'h7FFF, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    op(1'b1, 16'h8000, 16'h0001, 16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    op(1'b1, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);

    // start pulsed two cycles into RUN must be ignored.
    exp_q.push_back({16'h2225, 1'b0, 1'b0, 1'b0});
    exp_w_q.push_back({16'h2225, 1'b0, 1'b0, 1'b0});
    issue(1'b0, 16'h1234, 16'h0FF1);
    @(negedge clk);
    @(negedge clk);
    issue(1'b1, 16'hFFFF, 16'hFFFF);
    wait_done(cyc, nb);
    chk("ignored_start_remaining", 16'(cyc), 16'(2));

    // Back-to-back: each op is issued in the done cycle of the previous one.
    op(1'b0, 16'h0001, 16'h0001, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    op(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
    op(1'b1, 16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    op(1'b0, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);

    // Reset in the middle of an operation.
    issue(1'b0, 16'h1111, 16'h2222);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 16'(busy), 16'(0));
    chk("midrst_done", 16'(done), 16'(0));
    chk("midrst_result", result, 16'h0000);
    chk("midrst_flags", {13'b0, ovfl, cout, zero}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("no_activity_after_reset", 16'(ndone), 16'(0));
    op(1'b0, 16'h0005, 16'h0003, 16'h0008, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Single-nibble instance.
    op1(1'b0, 4'h7, 4'h1, 4'h7, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    op1(1'b1, 4'h8, 4'h1, 4'h8, 1'b1, 1'b1, 1'b0);
    op1(1'b0, 4'h3, 4'h4, 4'h7, 1'b0, 1'b0, 1'b0);
    op1(1'b0, 4'hF, 4'h1, 4'h0, 1'b0, 1'b1, 1'b1);

    repeat (4) @(negedge clk);
    chk("sat_queue_empty", 16'(exp_q.size()), 16'(0));
    chk("wrap_queue_empty", 16'(exp_w_q.size()), 16'(0));
    chk("n1_queue_empty", 16'(exp_1_q.size()), 16'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencer that computes a 4*NIBBLES-bit signed add or subtract by time-sharing one instance of the team's 4-bit carry-lookahead slice (CLA: A, B, CIN -> SUM, COUT, OVFL). It processes one nibble per cycle, LSB nibble first, and carries between cycles in a register. Used in area-constrained ALU paths where a full-width adder is not justified. It has a start/busy/done handshake, optional saturation, and flag outputs.

Parameters:
NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES; legal range 1..8.
SAT_EN, 1, 1 = saturate result on signed overflow; 0 = wrap (raw two's-complement result).

Ports:
clk  input  1  single clock, all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request; accepted only on a rising edge where busy==0.
sub  input  1  0 = A+B, 1 = A-B; sampled with start.
a  input  W  operand A; sampled with start.
b  input  W  operand B; sampled with start.
busy  output  1  high while an operation is in flight (state RUN).
done  output  1  single-cycle pulse; result and flags valid.
result  output  W  final sum/difference, held until the next accepted start.
ovfl  output  1  signed overflow of the raw result; held like result.
cout  output  1  carry out of the top nibble (for sub, 1 = no borrow); held.
zero  output  1  result==0, evaluated after saturation; held.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, nibble counter 0, carry reg 0, busy=0, done=0, result=0, ovfl=0, cout=0, zero=0. A reset mid-operation aborts it; no done is produced.
- States: IDLE, RUN, DONE. busy = (state==RUN). done = (state==DONE).
- Accept: on an edge with start=1 and state IDLE or DONE, latch opA=a and opB = sub ? ~b : b, carry reg = sub, counter = 0. Go to RUN. result and flags keep their old values until overwritten.
- While in RUN, start is ignored and has no effect on any state.
- RUN, each edge: drive the slice with opA[4k+3:4k], opB[4k+3:4k], CIN = carry reg, where k = counter. Write SUM into result[4k+3:4k] and set carry reg = COUT. If k < NIBBLES-1, increment k. If k == NIBBLES-1:
  - cout = COUT, ovfl = slice OVFL.
  - If SAT_EN and OVFL, write result = 0x7F..F when opA[W-1]==0, and 0x80..0 when opA[W-1]==1. This replaces all lower nibbles.
  - zero is computed from the final written value.
  - Go to DONE.
- DONE: lasts exactly one cycle, then go to IDLE, unless start is accepted on that edge, which goes to RUN. Back-to-back operations therefore have zero idle cycles.
- Latency: done is high during the cycle that begins exactly NIBBLES edges after the accepting edge. Throughput is one operation per NIBBLES+1 cycles.
- Intermediate result nibbles are visible during RUN. result is defined as valid only when done=1, or while idle after done.
- The counter is clog2(NIBBLES) bits wide (minimum 1). NIBBLES=1 yields 1-cycle RUN.

Test Plan:
- Add: NIBBLES=4, sub=0, a=0x1234, b=0x0FF1 -> after 4 cycles done=1, result=0x2225, ovfl=0, cout=0, zero=0; busy high for exactly 4 cycles.
- Positive overflow: a=0x7FFF, b=0x0001, add -> SAT_EN=1 gives result=0x7FFF; SAT_EN=0 gives 0x8000. ovfl=1, cout=0 in both cases.
- Subtract: a=0x8000, b=0x0001, sub=1 -> result=0x8000 (sat), ovfl=1, cout=1. Also a=0x0005, b=0x0005, sub=1 -> result=0x0000, zero=1, cout=1, ovfl=0.
- Handshake: pulse start again 2 cycles into RUN with different operands -> ignored; first result is unchanged. Assert start in the done cycle (a=0x0001, b=0x0001) -> next done 4 cycles later with result=0x0002, and no IDLE cycle in between.
- Reset mid-op: drop rst_n after 2 RUN cycles -> busy, done, result and flags go to 0 immediately. After release, no done until a new start.
- Width corner: NIBBLES=1, a=0x7, b=0x1, add -> done 1 cycle after accept, result=0x7 (sat), ovfl=1.
